// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, drives the instruction memory address and fills the
// IF/ID register. Handles stall, branch redirect, halt and a post-reset boot bubble.
module instruction_fetch #(
  parameter int unsigned  L        = 16,
  parameter logic [L-1:0] RESET_PC = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         stall,
  input  logic         branch_taken,
  input  logic [L-1:0] branch_target,
  input  logic         halt,
  output logic [L-1:0] instr_address,
  input  logic [L-1:0] instruction,
  output logic         if_id_valid,
  output logic [L-1:0] if_id_instruction,
  output logic [L-1:0] if_id_pc,
  output logic         align_err,
  output logic [L-1:0] fetch_count,
  output logic         halted
);

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [L-1:0] pc_p0;
  logic         vld_p1;
  logic [L-1:0] instr_p1;
  logic [L-1:0] pc_p1;
  logic         align_err_q;
  logic [L-1:0] fetch_count_q;

  logic do_halt;
  logic do_branch;
  logic do_fetch;
  logic halted_o;

  function automatic logic [L-1:0] sat_inc(input logic [L-1:0] v);
    if (&v) return v;
    return v + L'(1);
  endfunction

  function automatic logic [L-1:0] align_pc(input logic [L-1:0] v);
    return {v[L-1:1], 1'b0};
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= BOOT;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      BOOT:    state_d = RUN;
      RUN:     if (halt) state_d = HALTED;
      HALTED:  state_d = HALTED;
      default: state_d = BOOT;
    endcase
  end

  // Priority within RUN: halt > branch > stall > normal fetch
  always_comb begin
    do_halt   = 1'b0;
    do_branch = 1'b0;
    do_fetch  = 1'b0;
    halted_o  = 1'b0;
    unique case (state_q)
      RUN: begin
        do_halt   = halt;
        do_branch = !halt && branch_taken;
        do_fetch  = !halt && !branch_taken && !stall;
      end
      HALTED:  halted_o = 1'b1;
      default: ;
    endcase
  end

  // Stage p0: program counter, presented combinationally to instruction memory
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_p0 <= RESET_PC;
    end else if (do_branch) begin
      pc_p0 <= align_pc(branch_target);
    end else if (do_fetch) begin
      pc_p0 <= pc_p0 + L'(2);
    end
  end

  // Stage p1: IF/ID register; branch and halt squash the in-flight fetch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1        <= 1'b0;
      instr_p1      <= '0;
      pc_p1         <= '0;
      align_err_q   <= 1'b0;
      fetch_count_q <= '0;
    end else begin
      align_err_q <= do_branch && branch_target[0];
      if (do_fetch) begin
        vld_p1        <= 1'b1;
        instr_p1      <= instruction;
        pc_p1         <= pc_p0;
        fetch_count_q <= sat_inc(fetch_count_q);
      end else if (do_halt || do_branch) begin
        vld_p1 <= 1'b0;
      end
    end
  end

  assign instr_address     = pc_p0;
  assign if_id_valid       = vld_p1;
  assign if_id_instruction = instr_p1;
  assign if_id_pc          = pc_p1;
  assign align_err         = align_err_q;
  assign fetch_count       = fetch_count_q;
  assign halted            = halted_o;

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
Fetch stage of the 16-bit core. It owns the program counter and drives the combinational instruction memory's address. It latches the returned instruction into the IF/ID pipeline register consumed by decode. It handles stall, branch redirect, halt, and a one-cycle boot bubble after reset.

Parameters:
L, 16, datapath and address width in bits
RESET_PC, 0, PC value loaded on reset; bit 0 must be 0

Ports:
Clk  input  1  rising-edge clock
Reset_n  input  1  asynchronous active-low reset
Stall  input  1  hazard unit: hold PC and IF/ID register
BranchTaken  input  1  execute: redirect fetch this cycle
BranchTarget  input  L  redirect address
Halt  input  1  decode: stop fetching
InstrAddress  output  L  address to instruction memory (combinational from PC)
Instruction  input  L  instruction memory data, same-cycle response
IfIdValid  output  1  IF/ID register holds a real instruction
IfIdInstruction  output  L  latched instruction
IfIdPC  output  L  address of latched instruction
AlignErr  output  1  one-cycle pulse: BranchTarget[0] was 1
FetchCount  output  L  instructions accepted into IF/ID, saturating
Halted  output  1  block is in HALTED state

Behaviour:
- Reset (Reset_n=0, async), applied immediately:
  - PC=RESET_PC; state=BOOT.
  - IfIdValid=0, IfIdInstruction=0, IfIdPC=0, AlignErr=0, FetchCount=0, Halted=0.
- InstrAddress = PC at all times. The memory ignores bit 0; PC[0] is always 0.
- States: BOOT, RUN, HALTED.
- BOOT: lasts exactly one cycle after reset release. No fetch, IfIdValid stays 0, PC holds. Next state is RUN unconditionally; inputs are ignored.
- RUN, priority per rising edge is Halt > BranchTaken > Stall > normal:
  - Halt=1: enter HALTED; IfIdValid<=0; PC holds; FetchCount holds.
  - BranchTaken=1: PC<={BranchTarget[L-1:1],1'b0}; IfIdValid<=0 (squash the wrong-path fetch).
    - AlignErr<=BranchTarget[0].
    - Branch overrides a simultaneous Stall.
  - Stall=1 (no branch): PC, IfIdValid, IfIdInstruction, IfIdPC and FetchCount all hold.
  - Normal:
    - IfIdInstruction<=Instruction; IfIdPC<=PC; IfIdValid<=1; PC<=PC+2.
    - FetchCount<=FetchCount+1, saturating at 2^L-1.
- AlignErr is 0 on every edge where it is not set by a branch, so it is a single-cycle pulse.
- PC increment wraps modulo 2^L: PC=0xFFFE -> 0x0000, with no error.
- HALTED:
  - Halted=1; IfIdValid=0; all registers hold.
  - All inputs are ignored. Exit is by reset only.
- Reset asserted mid-operation (any state) takes effect asynchronously and clears everything as above. Release re-enters BOOT.
- Latency: instruction at PC appears on IfIdInstruction one edge after PC is presented, absent stall or branch.
- Throughput: one instruction per cycle.

Test Plan:
- Reset, then free run; bench memory returns 0x6002@0, 0x6403@2, 0xE401@4.
  -> Edge 1 after release: IfIdValid=0 (BOOT).
  -> Edges 2-4: IfIdPC=0,2,4; IfIdInstruction=0x6002,0x6403,0xE401; FetchCount=3.
- Stall held 3 cycles while IfIdPC=2.
  -> IfIdPC=2, IfIdInstruction=0x6403 and FetchCount are unchanged for the 3 cycles; InstrAddress=4 throughout.
  -> The next normal edge latches address 4.
- BranchTaken=1, BranchTarget=0x0011, with Stall=1 in the same cycle.
  -> IfIdValid=0 and AlignErr=1 for one cycle; InstrAddress=0x0010.
  -> The next edge latches IfIdPC=0x0010.
- Wrap: set via branch to 0xFFFE, free run.
  -> IfIdPC=0xFFFE then 0x0000; no AlignErr.
- Halt=1 together with BranchTaken=1.
  -> HALTED: Halted=1, IfIdValid=0, PC unchanged (branch ignored).
  -> Stall, Branch and Halt toggles have no effect for 10 cycles.
- Reset_n pulsed low mid-run, between clock edges.
  -> Outputs clear immediately without a clock: IfIdValid=0, FetchCount=0, InstrAddress=RESET_PC.
  -> After release, a BOOT bubble occurs, then fetch resumes from 0.
